// File: rtl/pipe_control_unit.sv
// Pipelined control unit for the 5-stage MIPS core: decodes the ID opcode, registers the
// control bundle into ID/EX, and handles load-use stalls, flushes and illegal opcodes.
module pipe_control_unit #(
  parameter int ALUOP_W    = 3,
  parameter int REG_AW     = 5,
  parameter int LOAD_STALL = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [5:0]         id_opcode,
  input  logic               id_valid,
  input  logic [REG_AW-1:0]  id_rs,
  input  logic [REG_AW-1:0]  id_rt,
  input  logic               flush,
  output logic               stall,
  output logic               ex_RegDst,
  output logic               ex_RegWrite,
  output logic               ex_MemRead,
  output logic               ex_MemtoReg,
  output logic               ex_MemWrite,
  output logic               ex_ALUSrc,
  output logic               ex_Branch,
  output logic               ex_BranchNe,
  output logic               ex_Jump,
  output logic [ALUOP_W-1:0] ex_ALUOp,
  output logic [REG_AW-1:0]  ex_rt,
  output logic               ex_valid,
  output logic               illegal_op
);

  typedef enum logic {RUN = 1'b0, STALL = 1'b1} state_t;

  localparam logic [1:0] CNT_INIT = (LOAD_STALL > 1) ? 2'(LOAD_STALL - 2) : 2'd0;

  state_t     state_reg, state_next;
  logic [1:0] cnt_reg, cnt_next;

  logic       dec_regdst, dec_regwrite, dec_memread, dec_memtoreg, dec_memwrite;
  logic       dec_alusrc, dec_branch, dec_branchne, dec_jump, dec_legal;
  logic [2:0] dec_aluop;
  logic [ALUOP_W-1:0] dec_aluop_ext;

  logic       hazard;
  logic       load_bubble;
  logic       illegal_next;

  always_comb begin
    dec_regdst   = 1'b0;
    dec_regwrite = 1'b0;
    dec_memread  = 1'b0;
    dec_memtoreg = 1'b0;
    dec_memwrite = 1'b0;
    dec_alusrc   = 1'b0;
    dec_branch   = 1'b0;
    dec_branchne = 1'b0;
    dec_jump     = 1'b0;
    dec_aluop    = 3'b000;
    dec_legal    = 1'b1;
    case (id_opcode)
      6'b000000: begin
        dec_regdst   = 1'b1;
        dec_regwrite = 1'b1;
        dec_aluop    = 3'b010;
      end
      6'b001000: begin
        dec_alusrc   = 1'b1;
        dec_regwrite = 1'b1;
        dec_aluop    = 3'b011;
      end
      6'b001100: begin
        dec_alusrc   = 1'b1;
        dec_regwrite = 1'b1;
        dec_aluop    = 3'b100;
      end
      6'b001101: begin
        dec_alusrc   = 1'b1;
        dec_regwrite = 1'b1;
        dec_aluop    = 3'b101;
      end
      6'b100011: begin
        dec_memread  = 1'b1;
        dec_memtoreg = 1'b1;
        dec_alusrc   = 1'b1;
        dec_regwrite = 1'b1;
      end
      6'b101011: begin
        dec_memwrite = 1'b1;
        dec_alusrc   = 1'b1;
      end
      6'b000100: begin
        dec_branch   = 1'b1;
        dec_aluop    = 3'b001;
      end
      6'b000101: begin
        dec_branch   = 1'b1;
        dec_branchne = 1'b1;
        dec_aluop    = 3'b001;
      end
      6'b000010: begin
        dec_jump     = 1'b1;
      end
      default: dec_legal = 1'b0;
    endcase
  end

  // ALUOp classes fit in 3 bits; wider fields are zero-filled above that.
  assign dec_aluop_ext[2:0] = dec_aluop;
  generate
    for (genvar gi = 3; gi < ALUOP_W; gi++) begin : g_aluop_fill
      assign dec_aluop_ext[gi] = 1'b0;
    end
  endgenerate

  assign hazard = ex_valid & ex_MemRead & (ex_rt != '0) & id_valid &
                  ((ex_rt == id_rs) | (ex_rt == id_rt));

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    stall        = 1'b0;
    load_bubble  = 1'b0;
    illegal_next = 1'b0;
    if (flush) begin
      state_next  = RUN;
      cnt_next    = 2'd0;
      load_bubble = 1'b1;
    end else begin
      case (state_reg)
        RUN: begin
          if (hazard) begin
            stall       = 1'b1;
            load_bubble = 1'b1;
            if (LOAD_STALL > 1) begin
              state_next = STALL;
              cnt_next   = CNT_INIT;
            end
          end else begin
            // Illegal opcodes enter EX as bubbles so nothing downstream acts on them.
            load_bubble  = ~id_valid | ~dec_legal;
            illegal_next = id_valid & ~dec_legal;
          end
        end
        STALL: begin
          stall       = 1'b1;
          load_bubble = 1'b1;
          if (cnt_reg == 2'd0) begin
            state_next = RUN;
          end else begin
            cnt_next = cnt_reg - 2'd1;
          end
        end
        default: begin
          state_next  = RUN;
          cnt_next    = 2'd0;
          load_bubble = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= RUN;
      cnt_reg   <= 2'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_RegDst   <= 1'b0;
      ex_RegWrite <= 1'b0;
      ex_MemRead  <= 1'b0;
      ex_MemtoReg <= 1'b0;
      ex_MemWrite <= 1'b0;
      ex_ALUSrc   <= 1'b0;
      ex_Branch   <= 1'b0;
      ex_BranchNe <= 1'b0;
      ex_Jump     <= 1'b0;
      ex_ALUOp    <= '0;
      ex_rt       <= '0;
      ex_valid    <= 1'b0;
      illegal_op  <= 1'b0;
    end else begin
      illegal_op <= illegal_next;
      if (load_bubble) begin
        ex_RegDst   <= 1'b0;
        ex_RegWrite <= 1'b0;
        ex_MemRead  <= 1'b0;
        ex_MemtoReg <= 1'b0;
        ex_MemWrite <= 1'b0;
        ex_ALUSrc   <= 1'b0;
        ex_Branch   <= 1'b0;
        ex_BranchNe <= 1'b0;
        ex_Jump     <= 1'b0;
        ex_ALUOp    <= '0;
        ex_rt       <= '0;
        ex_valid    <= 1'b0;
      end else begin
        ex_RegDst   <= dec_regdst;
        ex_RegWrite <= dec_regwrite;
        ex_MemRead  <= dec_memread;
        ex_MemtoReg <= dec_memtoreg;
        ex_MemWrite <= dec_memwrite;
        ex_ALUSrc   <= dec_alusrc;
        ex_Branch   <= dec_branch;
        ex_BranchNe <= dec_branchne;
        ex_Jump     <= dec_jump;
        ex_ALUOp    <= dec_aluop_ext;
        ex_rt       <= id_rt;
        ex_valid    <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pipe_control_unit.sv
// Directed bench for pipe_control_unit: decode table, load-use stalls with one and three
// bubbles, flush during a stall, illegal opcodes and asynchronous reset.
module tb_pipe_control_unit;

  logic       clk;
  logic       rst_n;
  logic [5:0] opc;
  logic       vld;
  logic [4:0] rs;
  logic [4:0] rt;
  logic       fl;

  logic [8:0] c1, c3;
  logic [2:0] a1, a3;
  logic [4:0] r1, r3;
  logic       v1, v3, i1, i3, s1, s3;

  int n_checks;
  int n_fail;

  pipe_control_unit #(.ALUOP_W(3), .REG_AW(5), .LOAD_STALL(1)) u1 (
    .clk(clk), .rst_n(rst_n), .id_opcode(opc), .id_valid(vld), .id_rs(rs), .id_rt(rt),
    .flush(fl), .stall(s1),
    .ex_RegDst(c1[8]), .ex_RegWrite(c1[7]), .ex_MemRead(c1[6]), .ex_MemtoReg(c1[5]),
    .ex_MemWrite(c1[4]), .ex_ALUSrc(c1[3]), .ex_Branch(c1[2]), .ex_BranchNe(c1[1]),
    .ex_Jump(c1[0]), .ex_ALUOp(a1), .ex_rt(r1), .ex_valid(v1), .illegal_op(i1)
  );

  pipe_control_unit #(.ALUOP_W(3), .REG_AW(5), .LOAD_STALL(3)) u3 (
    .clk(clk), .rst_n(rst_n), .id_opcode(opc), .id_valid(vld), .id_rs(rs), .id_rt(rt),
    .flush(fl), .stall(s3),
    .ex_RegDst(c3[8]), .ex_RegWrite(c3[7]), .ex_MemRead(c3[6]), .ex_MemtoReg(c3[5]),
    .ex_MemWrite(c3[4]), .ex_ALUSrc(c3[3]), .ex_Branch(c3[2]), .ex_BranchNe(c3[1]),
    .ex_Jump(c3[0]), .ex_ALUOp(a3), .ex_rt(r3), .ex_valid(v3), .illegal_op(i3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [5:0] op;
    logic [8:0] ctrl;
    logic [2:0] alu;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  task automatic drive(input logic [5:0] o, input logic v, input logic [4:0] s, input logic [4:0] t);
    opc = o;
    vld = v;
    rs  = s;
    rt  = t;
  endtask

  // Reset asserted between edges, released on a falling edge.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    fl    = 1'b0;
    drive(6'b111111, 1'b0, 5'd0, 5'd0);
    #2;
    chk("reset_ex_valid", {31'd0, v1 | v3}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int stalls;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    fl       = 1'b0;
    drive(6'd0, 1'b0, 5'd0, 5'd0);

    tbl[0] = '{6'b000000, 9'b110000000, 3'b010};
    tbl[1] = '{6'b001000, 9'b010001000, 3'b011};
    tbl[2] = '{6'b001100, 9'b010001000, 3'b100};
    tbl[3] = '{6'b001101, 9'b010001000, 3'b101};
    tbl[4] = '{6'b100011, 9'b011101000, 3'b000};
    tbl[5] = '{6'b101011, 9'b000011000, 3'b000};
    tbl[6] = '{6'b000100, 9'b000000100, 3'b001};
    tbl[7] = '{6'b000101, 9'b000000110, 3'b001};
    tbl[8] = '{6'b000010, 9'b000000001, 3'b000};

    #2;
    chk("reset_ctrl", {23'd0, c1}, 32'd0);
    chk("reset_illegal_stall", {29'd0, i1, s1, v1}, 32'd0);
    do_reset();

    // Decode table: distinct rt per entry so no load-use hazard arises.
    @(posedge clk);
    #1;
    for (int i = 0; i < 9; i++) begin
      drive(tbl[i].op, 1'b1, 5'd1, 5'(i + 3));
      #1;
      chk($sformatf("dec%0d_stall", i), {31'd0, s1 | s3}, 32'd0);
      tick();
      chk($sformatf("dec%0d_ctrl_u1", i), {23'd0, c1}, {23'd0, tbl[i].ctrl});
      chk($sformatf("dec%0d_ctrl_u3", i), {23'd0, c3}, {23'd0, tbl[i].ctrl});
      chk($sformatf("dec%0d_aluop", i), {29'd0, a1}, {29'd0, tbl[i].alu});
      chk($sformatf("dec%0d_rt_valid", i), {25'd0, r1, v1, i1}, {25'd0, 5'(i + 3), 1'b1, 1'b0});
    end

    // Load-use with one bubble (u1).
    do_reset();
    tick();
    drive(6'b100011, 1'b1, 5'd1, 5'd8);
    tick();
    drive(6'b000000, 1'b1, 5'd8, 5'd2);
    #1;
    chk("ls1_stall_hazard", {31'd0, s1}, 32'd1);
    tick();
    chk("ls1_bubble", {31'd0, v1}, 32'd0);
    chk("ls1_stall_released", {31'd0, s1}, 32'd0);
    tick();
    chk("ls1_rtype_issued", {25'd0, c1[8], r1, v1}, {25'd0, 1'b1, 5'd2, 1'b1});

    // Load-use with three bubbles (u3): hold the R-type while stall is high.
    do_reset();
    tick();
    drive(6'b100011, 1'b1, 5'd1, 5'd8);
    tick();
    drive(6'b000000, 1'b1, 5'd8, 5'd2);
    #1;
    stalls = 0;
    for (int k = 0; k < 8 && s3; k++) begin
      stalls++;
      tick();
      chk($sformatf("ls3_bubble%0d", k), {31'd0, v3}, 32'd0);
    end
    chk("ls3_stall_count", stalls, 32'd3);
    tick();
    chk("ls3_rtype_issued", {25'd0, c3[8], r3, v3}, {25'd0, 1'b1, 5'd2, 1'b1});

    // lw to $0 never stalls.
    do_reset();
    tick();
    drive(6'b100011, 1'b1, 5'd1, 5'd0);
    tick();
    drive(6'b000000, 1'b1, 5'd0, 5'd0);
    #1;
    chk("lw_r0_no_stall", {31'd0, s3}, 32'd0);
    tick();
    chk("lw_r0_issue", {31'd0, v3}, 32'd1);

    // Flush on the second stall cycle of a three-bubble stall.
    do_reset();
    tick();
    drive(6'b100011, 1'b1, 5'd1, 5'd8);
    tick();
    drive(6'b000000, 1'b1, 5'd8, 5'd2);
    #1;
    chk("flush_stall1", {31'd0, s3}, 32'd1);
    tick();
    chk("flush_stall2", {31'd0, s3}, 32'd1);
    fl = 1'b1;
    #1;
    chk("flush_drops_stall", {31'd0, s3}, 32'd0);
    tick();
    fl = 1'b0;
    #1;
    chk("flush_bubble_run", {30'd0, v3, s3}, 32'd0);
    tick();
    chk("flush_then_issue", {31'd0, v3}, 32'd1);

    // Illegal opcode, valid then invalid.
    do_reset();
    tick();
    drive(6'b111111, 1'b1, 5'd1, 5'd2);
    tick();
    chk("illegal_pulse", {31'd0, i1}, 32'd1);
    chk("illegal_ex_zero", {19'd0, c1, a1, v1}, 32'd0);
    drive(6'b000000, 1'b1, 5'd1, 5'd2);
    tick();
    chk("illegal_one_cycle", {31'd0, i1}, 32'd0);
    drive(6'b111111, 1'b0, 5'd1, 5'd2);
    tick();
    chk("illegal_invalid_no_pulse", {30'd0, i1, v1}, 32'd0);

    // Asynchronous reset while a stall is in progress with RegWrite set in EX.
    do_reset();
    tick();
    drive(6'b100011, 1'b1, 5'd1, 5'd8);
    tick();
    drive(6'b000000, 1'b1, 5'd8, 5'd2);
    #1;
    chk("rst_pre_state", {29'd0, s3, c3[7], v3}, 32'd7);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_async_ctrl", {19'd0, c3, a3, v3}, 32'd0);
    chk("rst_async_rt_ill_stall", {25'd0, r3, i3, s3}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_release_stall", {31'd0, s3}, 32'd0);
    tick();
    chk("rst_release_issue", {30'd0, v3, s3}, 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_control_unit.md
Name: pipe_control_unit

Overview:
- Pipelined successor to the single-cycle opcode decoder for the 5-stage MIPS core.
- Decodes the ID-stage opcode into the control bundle and registers it into the ID/EX pipeline stage.
- Also provides load-use hazard detection with a parametrised bubble count, branch/jump flush, and illegal-opcode flagging.
- Sits between the IF/ID register and the EX stage; its `stall` output gates the PC and IF/ID write enables.

Parameters:
- ALUOP_W, 3, width of the ALUOp field (must be ≥3; upper bits zero-filled).
- REG_AW, 5, register-address width.
- LOAD_STALL, 1, bubbles inserted per load-use hazard (legal 1..3; covers multi-cycle data memory).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_opcode  in  6  opcode field of the instruction in ID.
- id_valid  in  1  ID holds a real instruction (0 = bubble).
- id_rs  in  REG_AW  rs field in ID.
- id_rt  in  REG_AW  rt field in ID.
- flush  in  1  branch taken / jump from EX; kill the ID instruction.
- stall  out  1  combinational; hold PC and IF/ID this cycle.
- ex_RegDst, ex_RegWrite, ex_MemRead, ex_MemtoReg, ex_MemWrite, ex_ALUSrc  out  1 each  registered control bits.
- ex_Branch, ex_BranchNe, ex_Jump  out  1 each  registered branch controls.
- ex_ALUOp  out  ALUOP_W  registered ALU operation class.
- ex_rt  out  REG_AW  registered rt of the EX instruction.
- ex_valid  out  1  EX holds a real instruction.
- illegal_op  out  1  one-cycle registered pulse for an unknown opcode with id_valid=1.

Behaviour:
- Decode table (combinational, then registered). Listed bits = 1, all others 0:
  - 000000 R-type: RegDst, RegWrite, ALUOp=010.
  - 001000 addi: ALUSrc, RegWrite, ALUOp=011.
  - 001100 andi: ALUSrc, RegWrite, ALUOp=100.
  - 001101 ori: ALUSrc, RegWrite, ALUOp=101.
  - 100011 lw: MemRead, MemtoReg, ALUSrc, RegWrite, ALUOp=000.
  - 101011 sw: MemWrite, ALUSrc, ALUOp=000.
  - 000100 beq: Branch, ALUOp=001.
  - 000101 bne: Branch, BranchNe, ALUOp=001.
  - 000010 j: Jump, ALUOp=000.
  - Any other opcode: all zero, illegal.
- Latency: one cycle from ID inputs to ex_* outputs.
- Bubble: all ex_* control bits 0, ex_ALUOp=0, ex_valid=0, ex_rt=0.
- Hazard: `hazard = ex_valid & ex_MemRead & (ex_rt != 0) & id_valid & ((ex_rt == id_rs) | (ex_rt == id_rt))`.
- FSM states RUN and STALL, plus a 2-bit counter cnt.
  - RUN, no hazard: register the decoded ID bundle; stall=0.
  - RUN, hazard: stall=1; EX loads a bubble. If LOAD_STALL>1, go to STALL with cnt=LOAD_STALL-2; else stay in RUN.
  - STALL: stall=1; EX loads a bubble. If cnt==0 go to RUN, else decrement cnt.
  - Total stall cycles per hazard = LOAD_STALL exactly; the held ID instruction issues on the following cycle.
- flush (highest priority, any state):
  - stall forced 0 combinationally.
  - At the edge: EX loads a bubble, state←RUN, cnt←0, illegal_op←0.
- id_valid=0: EX loads a bubble; no hazard and no illegal pulse.
- illegal_op: registered 1 for one cycle when ID holds an unknown opcode, id_valid=1, and no stall or flush that cycle.
- Reset (async, rst_n=0):
  - All ex_* outputs 0; ex_valid=0; illegal_op=0.
  - state=RUN, cnt=0; stall=0.
  - Reset mid-STALL abandons the stall immediately.
  - First capture occurs on the first rising edge after rst_n deasserts.

Test Plan:
- Reset then opcode sequence 000000, 001000, 001100, 001101, 100011, 101011, 000100, 000101, 000010, id_valid=1, no hazards → each ex_* bundle matches the table one cycle later; ex_ALUOp = 010, 011, 100, 101, 000, 000, 001, 001, 000.
- lw with rt=8 followed by R-type with rs=8, LOAD_STALL=1 → stall=1 for exactly 1 cycle; one bubble (ex_valid=0) in EX; R-type reaches EX on the next cycle.
- Same sequence with LOAD_STALL=3 → stall high for 3 consecutive cycles; 3 bubbles; then the R-type issues. Repeat with lw rt=0 → no stall.
- Hazard stall in progress (LOAD_STALL=3, second stall cycle) with flush=1 → stall drops that cycle; next cycle ex_valid=0, state RUN, no further stall.
- Opcode 111111 with id_valid=1 → all ex_* zero and a one-cycle illegal_op pulse. Same opcode with id_valid=0 → no pulse.
- rst_n pulled low asynchronously mid-STALL with ex_RegWrite=1 → all outputs 0 immediately (before the next edge); stall=0 after release.
